// File: rtl/mux41_if.sv
// 4-to-1 WIDTH-bit selector with a combinational output and a registered copy
// (enable, captured select, change pulse). Define MUX41_PARITY_EN to add y_par.
module mux41_if #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q,
    output logic             chg
`ifdef MUX41_PARITY_EN
    ,
    output logic             y_par
`endif
);

    logic [WIDTH-1:0] y_d;
    logic [1:0]       sel_d;
    logic             chg_d;

    // Full decode; an X on sel falls to the default arm, which is acceptable.
    always_comb begin
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
    end

    always_comb begin
        y_d   = y_q;
        sel_d = sel_q;
        chg_d = 1'b0;
        if (en) begin
            y_d   = y;
            sel_d = sel;
            chg_d = (y != y_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= 2'b00;
            chg   <= 1'b0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
            chg   <= chg_d;
        end
    end

`ifdef MUX41_PARITY_EN
    // Parity is taken from y so it lands in the same cycle as y_q.
    logic par_d;
    assign par_d = en ? ^y : y_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_par <= 1'b0;
        else        y_par <= par_d;
    end
`endif

endmodule

// File: tb/tb_mux41_if.sv
// Directed bench for mux41_if: combinational select, register stage, async reset.
module tb_mux41_if;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a, b, c, d;
    logic [WIDTH-1:0] y, y_q;
    logic [1:0]       sel_q;
    logic             chg;
`ifdef MUX41_PARITY_EN
    logic             y_par;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux41_if #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .sel   (sel),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q),
        .chg   (chg)
`ifdef MUX41_PARITY_EN
        ,
        .y_par (y_par)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sel = 2'b00;
        a = '0; b = '0; c = '0; d = '0;
        #2;
        total++;
        if (y_q !== 4'b0000 || sel_q !== 2'b00 || chg !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: y_q=%b sel_q=%b chg=%b, want 0000 00 0", y_q, sel_q, chg);
        end
    endtask

    task automatic test_comb();
        logic [3:0] exp1 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp2 [5] = '{4'b1100, 4'b0011, 4'b0110, 4'b1001, 4'b1100};
        a = 4'b0001; b = 4'b0010; c = 4'b0100; d = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            total++;
            if (y !== exp1[i]) begin
                bad++;
                $display("FAIL comb_set1 sel=%0d: y=%b want %b", i, y, exp1[i]);
            end
            #19;
        end
        a = 4'b1100; b = 4'b0011; c = 4'b0110; d = 4'b1001;
        // Five steps so sel wraps 11 -> 00 and selects a again.
        for (int i = 0; i < 5; i++) begin
            sel = 2'(i);
            #1;
            total++;
            if (y !== exp2[i]) begin
                bad++;
                $display("FAIL comb_set2 step=%0d: y=%b want %b", i, y, exp2[i]);
            end
            #19;
        end
    endtask

    task automatic test_first_load_zero();
        a = 4'b0000; sel = 2'b00; en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (y_q !== 4'b0000 || chg !== 1'b0) begin
            bad++;
            $display("FAIL first_load_zero: y_q=%b chg=%b want 0000 0", y_q, chg);
        end
    endtask

    task automatic test_load_chg();
        c = 4'b0110; sel = 2'b10; en = 1'b1;
        tick();
        total++;
        if (y_q !== 4'b0110 || sel_q !== 2'b10 || chg !== 1'b1) begin
            bad++;
            $display("FAIL load_chg: y_q=%b sel_q=%b chg=%b want 0110 10 1", y_q, sel_q, chg);
        end
        tick();
        total++;
        if (chg !== 1'b0 || y_q !== 4'b0110) begin
            bad++;
            $display("FAIL load_nochg: y_q=%b chg=%b want 0110 0", y_q, chg);
        end
    endtask

    task automatic test_hold();
        en = 1'b0; b = 4'b1111; sel = 2'b01;
        tick();
        tick();
        total++;
        if (y_q !== 4'b0110 || sel_q !== 2'b10 || chg !== 1'b0) begin
            bad++;
            $display("FAIL hold: y_q=%b sel_q=%b chg=%b want 0110 10 0", y_q, sel_q, chg);
        end
        total++;
        if (y !== 4'b1111) begin
            bad++;
            $display("FAIL hold_comb: y=%b want 1111", y);
        end
    endtask

    task automatic test_simultaneous();
        en = 1'b1; sel = 2'b11; d = 4'b1001;
        tick();
        total++;
        if (y_q !== 4'b1001 || sel_q !== 2'b11 || chg !== 1'b1) begin
            bad++;
            $display("FAIL simultaneous: y_q=%b sel_q=%b chg=%b want 1001 11 1", y_q, sel_q, chg);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (y_q !== 4'b0000 || sel_q !== 2'b00 || chg !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: y_q=%b sel_q=%b chg=%b want 0000 00 0", y_q, sel_q, chg);
        end
        total++;
        if (y !== 4'b1001) begin
            bad++;
            $display("FAIL reset_comb: y=%b want 1001", y);
        end
        tick();
        total++;
        if (y_q !== 4'b0000 || chg !== 1'b0) begin
            bad++;
            $display("FAIL reset_wins_en: y_q=%b chg=%b want 0000 0", y_q, chg);
        end
        rst_n = 1'b1;
        #2;
        total++;
        if (y_q !== 4'b0000) begin
            bad++;
            $display("FAIL release_wait: y_q=%b want 0000", y_q);
        end
        tick();
        total++;
        if (y_q !== 4'b1001 || sel_q !== 2'b11 || chg !== 1'b1) begin
            bad++;
            $display("FAIL release_load: y_q=%b sel_q=%b chg=%b want 1001 11 1", y_q, sel_q, chg);
        end
    endtask

    task automatic test_wrap_registered();
        a = 4'b1100; sel = 2'b00;
        tick();
        total++;
        if (y_q !== 4'b1100 || sel_q !== 2'b00 || chg !== 1'b1) begin
            bad++;
            $display("FAIL wrap_reg: y_q=%b sel_q=%b chg=%b want 1100 00 1", y_q, sel_q, chg);
        end
    endtask

`ifdef MUX41_PARITY_EN
    task automatic test_parity();
        en = 1'b1; sel = 2'b00; a = 4'b0111;
        tick();
        total++;
        if (y_par !== 1'b1) begin
            bad++;
            $display("FAIL parity_0111: y_par=%b want 1", y_par);
        end
        a = 4'b0011;
        tick();
        total++;
        if (y_par !== 1'b0) begin
            bad++;
            $display("FAIL parity_0011: y_par=%b want 0", y_par);
        end
        a = 4'b0111;
        tick();
        en = 1'b0; a = 4'b0011;
        tick();
        total++;
        if (y_par !== 1'b1) begin
            bad++;
            $display("FAIL parity_hold: y_par=%b want 1", y_par);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (y_par !== 1'b0) begin
            bad++;
            $display("FAIL parity_reset: y_par=%b want 0", y_par);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_comb();
        test_first_load_zero();
        test_load_chg();
        test_hold();
        test_simultaneous();
        test_async_reset();
        test_wrap_registered();
`ifdef MUX41_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
